// File: rtl/stream_test_ctrl_if.sv
// Control/status bundle between the test sequencer (master) and the bench side (slave).
// Pure wiring, no latency; level signals with no handshake or backpressure.
interface stream_test_ctrl_if #(
    parameter int NumSpies = 2
) ();
    logic                start;
    logic [NumSpies-1:0] spy_done;
    logic [NumSpies-1:0] spy_err;
    logic                src_enable;
    logic                busy;
    logic                pass;
    logic                fail;
    logic                timeout;
    logic [NumSpies-1:0] err_mask;
    logic [31:0]         cycle_count;

    modport master (
        input  start, spy_done, spy_err,
        output src_enable, busy, pass, fail, timeout, err_mask, cycle_count
    );

    modport slave (
        output start, spy_done, spy_err,
        input  src_enable, busy, pass, fail, timeout, err_mask, cycle_count
    );
endinterface

// File: rtl/stream_test_ctrl.sv
// Test sequencer: start -> RUN (sources on) -> DRAIN -> sticky PASS/FAIL with watchdog and error mask.
// All outputs registered (one cycle after the causing input); no backpressure, spies are level inputs.
module stream_test_ctrl #(
    parameter int          NumSpies      = 2,
    parameter int unsigned TimeoutCycles = 100000,
    parameter int unsigned DrainCycles   = 16,
    parameter bit          StopOnErr     = 1'b1,
    parameter bit          FinishSim     = 1'b1,
    parameter string       TestName      = "undefined",
    parameter bit          PrintMsgs     = 1'b1
) (
    input logic              clk,
    input logic              rst,
    stream_test_ctrl_if.master bus
);

    if (NumSpies < 1 || DrainCycles < 1) begin : g_bad_param
        $error("stream_test_ctrl: NumSpies and DrainCycles must both be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles - 1);
    localparam logic [31:0] DrainLast   = 32'(DrainCycles - 1);

    state_t              state_q, state_d;
    logic [31:0]         cycle_count_q, cycle_count_d;
    logic [31:0]         drain_cnt_q, drain_cnt_d;
    logic [NumSpies-1:0] err_mask_q, err_mask_d;
    logic                timeout_q, timeout_d;
    logic                src_enable_q, busy_q, pass_q, fail_q;

    logic any_err;
    logic all_done;

    assign any_err  = |bus.spy_err;
    assign all_done = &bus.spy_done;

    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        drain_cnt_d   = drain_cnt_q;
        err_mask_d    = err_mask_q;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = ST_RUN;
                    cycle_count_d = '0;
                    drain_cnt_d   = '0;
                    err_mask_d    = '0;
                    timeout_d     = 1'b0;
                end
            end

            ST_RUN: begin
                err_mask_d = err_mask_q | bus.spy_err;
                if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                // Error beats all-done, and all-done beats the watchdog.
                if (StopOnErr && any_err) begin
                    state_d = ST_FAIL;
                end else if (all_done) begin
                    state_d = ST_DRAIN;
                end else if ((TimeoutCycles != 0) && (cycle_count_q == TimeoutLast)) begin
                    state_d   = ST_FAIL;
                    timeout_d = 1'b1;
                end
            end

            ST_DRAIN: begin
                err_mask_d = err_mask_q | bus.spy_err;
                if (StopOnErr && any_err) begin
                    state_d = ST_FAIL;
                end else if (drain_cnt_q == DrainLast) begin
                    state_d = (err_mask_d == '0) ? ST_PASS : ST_FAIL;
                end else begin
                    drain_cnt_d = drain_cnt_q + 32'd1;
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cycle_count_q <= '0;
            drain_cnt_q   <= '0;
            err_mask_q    <= '0;
            timeout_q     <= 1'b0;
            src_enable_q  <= 1'b0;
            busy_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            drain_cnt_q   <= drain_cnt_d;
            err_mask_q    <= err_mask_d;
            timeout_q     <= timeout_d;
            src_enable_q  <= (state_d == ST_RUN);
            busy_q        <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            pass_q        <= (state_d == ST_PASS);
            fail_q        <= (state_d == ST_FAIL);
        end
    end

    assign bus.src_enable  = src_enable_q;
    assign bus.busy        = busy_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.timeout     = timeout_q;
    assign bus.err_mask    = err_mask_q;
    assign bus.cycle_count = cycle_count_q;

`ifndef SYNTHESIS
    // Messages fire on the entry edge only; terminal states never re-enter without a reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (PrintMsgs && (state_q != ST_PASS) && (state_d == ST_PASS)) begin
                $display("PASS: (\"%s\") %0d cycles", TestName, cycle_count_d);
            end
            if (PrintMsgs && (state_q != ST_FAIL) && (state_d == ST_FAIL)) begin
                if (timeout_d) begin
                    $display("FAIL: (\"%s\") timeout, %0d cycles", TestName, cycle_count_d);
                end else begin
                    $display("FAIL: (\"%s\") err_mask=0x%0h, %0d cycles",
                             TestName, err_mask_d, cycle_count_d);
                end
            end
            if (FinishSim && (pass_q || fail_q)) begin
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_test_ctrl.sv
// Directed bench for stream_test_ctrl: two instances (stop-on-error and accumulate) sharing a clock.
module tb_stream_test_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus is steered to one DUT at a time; the idle one is held in reset.
    logic       sel     = 1'b0;
    logic       rst_v   = 1'b1;
    logic       start_v = 1'b0;
    logic [1:0] done_v  = 2'b00;
    logic [1:0] err_v   = 2'b00;

    logic rst_a, rst_b;
    assign rst_a = sel ? 1'b1 : rst_v;
    assign rst_b = sel ? rst_v : 1'b1;

    stream_test_ctrl_if #(.NumSpies(2)) ifc_a ();
    stream_test_ctrl_if #(.NumSpies(2)) ifc_b ();

    assign ifc_a.start    = sel ? 1'b0  : start_v;
    assign ifc_a.spy_done = sel ? 2'b00 : done_v;
    assign ifc_a.spy_err  = sel ? 2'b00 : err_v;
    assign ifc_b.start    = sel ? start_v : 1'b0;
    assign ifc_b.spy_done = sel ? done_v  : 2'b00;
    assign ifc_b.spy_err  = sel ? err_v   : 2'b00;

    stream_test_ctrl #(
        .NumSpies(2), .TimeoutCycles(20), .DrainCycles(4), .StopOnErr(1'b1),
        .FinishSim(1'b0), .TestName("stop_on_err"), .PrintMsgs(1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifc_a.master)
    );

    stream_test_ctrl #(
        .NumSpies(2), .TimeoutCycles(20), .DrainCycles(4), .StopOnErr(1'b0),
        .FinishSim(1'b0), .TestName("accumulate"), .PrintMsgs(1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifc_b.master)
    );

    logic        o_src, o_busy, o_pass, o_fail, o_tmo;
    logic [1:0]  o_mask;
    logic [31:0] o_cnt;
    assign o_src  = sel ? ifc_b.src_enable  : ifc_a.src_enable;
    assign o_busy = sel ? ifc_b.busy        : ifc_a.busy;
    assign o_pass = sel ? ifc_b.pass        : ifc_a.pass;
    assign o_fail = sel ? ifc_b.fail        : ifc_a.fail;
    assign o_tmo  = sel ? ifc_b.timeout     : ifc_a.timeout;
    assign o_mask = sel ? ifc_b.err_mask    : ifc_a.err_mask;
    assign o_cnt  = sel ? ifc_b.cycle_count : ifc_a.cycle_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic which);
        sel     = which;
        rst_v   = 1'b1;
        start_v = 1'b0;
        done_v  = 2'b00;
        err_v   = 2'b00;
        step(2);
        rst_v = 1'b0;
    endtask

    // Leaves the DUT in RUN cycle 0 (cycle_count == 0).
    task automatic start_run();
        start_v = 1'b1;
        step();
        start_v = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".src"},  32'(o_src),  32'd0);
        chk({tag, ".busy"}, 32'(o_busy), 32'd0);
        chk({tag, ".pass"}, 32'(o_pass), 32'd0);
        chk({tag, ".fail"}, 32'(o_fail), 32'd0);
        chk({tag, ".tmo"},  32'(o_tmo),  32'd0);
        chk({tag, ".mask"}, 32'(o_mask), 32'd0);
        chk({tag, ".cnt"},  o_cnt,       32'd0);
    endtask

    initial begin
        // 1: clean run, done at RUN cycle 10, 4-cycle drain, PASS with count 11
        do_reset(1'b0);
        chk_all_zero("rst");
        step();
        chk("idle.src", 32'(o_src), 32'd0);
        start_run();
        for (int k = 0; k < 10; k++) begin
            chk("t1.run_src", 32'(o_src), 32'd1);
            chk("t1.run_cnt", o_cnt, 32'(k));
            step();
        end
        chk("t1.run10_src", 32'(o_src), 32'd1);
        done_v = 2'b11;
        step();
        done_v = 2'b00;
        chk("t1.drain_src",  32'(o_src),  32'd0);
        chk("t1.drain_busy", 32'(o_busy), 32'd1);
        chk("t1.drain_cnt",  o_cnt,       32'd11);
        step(3);
        chk("t1.drain3_busy", 32'(o_busy), 32'd1);
        chk("t1.drain3_pass", 32'(o_pass), 32'd0);
        step();
        chk("t1.pass",  32'(o_pass), 32'd1);
        chk("t1.fail",  32'(o_fail), 32'd0);
        chk("t1.busy",  32'(o_busy), 32'd0);
        chk("t1.mask",  32'(o_mask), 32'd0);
        chk("t1.cnt",   o_cnt,       32'd11);

        // 2: error at RUN cycle 5 stops the run on the next edge
        do_reset(1'b0);
        start_run();
        step(5);
        chk("t2.pre_fail", 32'(o_fail), 32'd0);
        err_v = 2'b10;
        step();
        err_v = 2'b00;
        chk("t2.fail", 32'(o_fail), 32'd1);
        chk("t2.src",  32'(o_src),  32'd0);
        chk("t2.mask", 32'(o_mask), 32'd2);
        chk("t2.tmo",  32'(o_tmo),  32'd0);
        chk("t2.cnt",  o_cnt,       32'd6);
        step(2);
        chk("t2.hold_fail", 32'(o_fail), 32'd1);
        chk("t2.hold_cnt",  o_cnt,       32'd6);

        // 3: watchdog fires after exactly 20 RUN cycles
        do_reset(1'b0);
        start_run();
        step(19);
        chk("t3.c19_src",  32'(o_src),  32'd1);
        chk("t3.c19_fail", 32'(o_fail), 32'd0);
        step();
        chk("t3.fail", 32'(o_fail), 32'd1);
        chk("t3.tmo",  32'(o_tmo),  32'd1);
        chk("t3.cnt",  o_cnt,       32'd20);
        chk("t3.mask", 32'(o_mask), 32'd0);

        // 4: accumulate mode, error at cycle 3, done at cycle 8 -> DRAIN -> FAIL
        do_reset(1'b1);
        start_run();
        step(3);
        err_v = 2'b01;
        step(5);
        chk("t4.run_src",  32'(o_src),  32'd1);
        chk("t4.run_mask", 32'(o_mask), 32'd1);
        chk("t4.run_fail", 32'(o_fail), 32'd0);
        done_v = 2'b11;
        step();
        chk("t4.drain_busy", 32'(o_busy), 32'd1);
        chk("t4.drain_src",  32'(o_src),  32'd0);
        chk("t4.drain_fail", 32'(o_fail), 32'd0);
        step(3);
        chk("t4.drain3_busy", 32'(o_busy), 32'd1);
        step();
        chk("t4.fail", 32'(o_fail), 32'd1);
        chk("t4.pass", 32'(o_pass), 32'd0);
        chk("t4.mask", 32'(o_mask), 32'd1);
        chk("t4.tmo",  32'(o_tmo),  32'd0);
        chk("t4.cnt",  o_cnt,       32'd9);

        // 5a: error and all-done together -> FAIL, not DRAIN
        do_reset(1'b0);
        start_run();
        step(2);
        err_v  = 2'b01;
        done_v = 2'b11;
        step();
        chk("t5a.fail", 32'(o_fail), 32'd1);
        chk("t5a.busy", 32'(o_busy), 32'd0);
        chk("t5a.mask", 32'(o_mask), 32'd1);
        chk("t5a.cnt",  o_cnt,       32'd3);

        // 5b: error on the last DRAIN cycle
        do_reset(1'b0);
        start_run();
        done_v = 2'b11;
        step();
        done_v = 2'b00;
        step(3);
        chk("t5b.d3_busy", 32'(o_busy), 32'd1);
        err_v = 2'b10;
        step();
        err_v = 2'b00;
        chk("t5b.fail", 32'(o_fail), 32'd1);
        chk("t5b.pass", 32'(o_pass), 32'd0);
        chk("t5b.mask", 32'(o_mask), 32'd2);

        // 6: reset during DRAIN, then a fresh run to PASS; start ignored in PASS
        do_reset(1'b0);
        start_run();
        step();
        done_v = 2'b11;
        step();
        done_v = 2'b00;
        step();
        chk("t6.drain_busy", 32'(o_busy), 32'd1);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        chk_all_zero("t6.rst");
        step();
        chk("t6.idle_busy", 32'(o_busy), 32'd0);
        start_run();
        step(2);
        done_v = 2'b11;
        step();
        done_v = 2'b00;
        step(4);
        chk("t6.pass", 32'(o_pass), 32'd1);
        chk("t6.cnt",  o_cnt,       32'd3);
        start_v = 1'b1;
        step();
        start_v = 1'b0;
        step();
        chk("t6.pass_hold", 32'(o_pass), 32'd1);
        chk("t6.busy_hold", 32'(o_busy), 32'd0);
        chk("t6.src_hold",  32'(o_src),  32'd0);
        chk("t6.cnt_hold",  o_cnt,       32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/stream_test_ctrl.md
Name: stream_test_ctrl

Overview:
Simulation test sequencer that sits above a set of stream sources and stream spies in a testbench. After a start pulse it enables the sources, then watches every spy's done/err flags. It enforces a watchdog timeout and allows a drain window for trailing transactions. It then reports a single sticky pass/fail verdict, prints a summary and optionally ends the simulation.

Parameters:
NumSpies, 2, number of spies monitored (must be >= 1)
TimeoutCycles, 100000, RUN-state watchdog limit in cycles; 0 disables the watchdog
DrainCycles, 16, cycles spent in DRAIN after all spies report done (must be >= 1)
StopOnErr, 1, 1: first error ends the run immediately; 0: errors accumulate and the run continues
FinishSim, 1, 1: call $finish one cycle after entering PASS or FAIL
TestName, "undefined", string printed in the summary messages

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  begin the test; sampled only in IDLE
spy_done  input  NumSpies  per-spy done flag (level)
spy_err  input  NumSpies  per-spy error flag (level, sticky in spy)
src_enable  output  1  enables the stream sources; high only in RUN
busy  output  1  high in RUN or DRAIN
pass  output  1  sticky; high in PASS
fail  output  1  sticky; high in FAIL
timeout  output  1  sticky; set when FAIL was caused by the watchdog
err_mask  output  NumSpies  latched OR of spy_err seen during RUN and DRAIN
cycle_count  output  32  cycles spent in RUN; saturates at 0xFFFFFFFF

Behaviour:
- All outputs are registered. On rst all outputs are 0, state is IDLE, the counters are cleared and no message is printed. Reset mid-run aborts silently back to IDLE.
- States: IDLE, RUN, DRAIN, PASS, FAIL.
- IDLE:
  - start=1 -> RUN at the next edge; cycle_count, err_mask and the drain counter are cleared on entry.
  - src_enable rises in the cycle after start is sampled.
- RUN:
  - src_enable=1, busy=1. cycle_count increments once per RUN cycle and saturates.
  - Each cycle: err_mask <= err_mask | spy_err.
  - Transition priority, evaluated per cycle:
    - (1) |spy_err and StopOnErr=1 -> FAIL.
    - (2) &spy_done -> DRAIN.
    - (3) TimeoutCycles!=0 and cycle_count==TimeoutCycles-1 -> FAIL with timeout<=1.
  - An error and all-done in the same cycle with StopOnErr=1 -> FAIL (error wins).
  - All-done on the timeout cycle -> DRAIN (no timeout).
- DRAIN:
  - src_enable=0, busy=1. The drain counter counts 0..DrainCycles-1.
  - spy_err is still accumulated into err_mask.
  - Any new spy_err bit with StopOnErr=1 -> FAIL immediately.
  - At count DrainCycles-1 -> PASS if err_mask==0 (including the same-cycle spy_err), else FAIL.
  - spy_done deasserting during DRAIN is ignored.
- PASS / FAIL:
  - Terminal until rst; start is ignored. busy=0, src_enable=0.
  - pass/fail, timeout, err_mask and cycle_count hold.
- Messages, printed once in the cycle of entry:
  - PASS: "PASS: (\"<TestName>\") <cycle_count> cycles".
  - FAIL: "FAIL: (\"<TestName>\")" followed by reason (timeout, or err_mask in hex) and cycle_count.
- If FinishSim=1, $finish is called on the edge after pass or fail is first high.
- StopOnErr=0: a run with errors still runs to all-done or timeout, passes through DRAIN, then ends in FAIL with the full err_mask.
- cycle_count does not advance in DRAIN. A timeout exactly at saturation is not reachable because TimeoutCycles fits in 32 bits.

Test Plan:
1. NumSpies=2, DrainCycles=4, FinishSim=0. Pulse start at cycle 0; spy_done=2'b11 at RUN cycle 10, no errors.
   -> src_enable high for cycles 1..11; DRAIN for 4 cycles; pass=1 with cycle_count=11, fail=0, err_mask=0.
2. StopOnErr=1. spy_err=2'b10 at RUN cycle 5.
   -> FAIL on the next edge; src_enable drops; err_mask=2'b10, timeout=0, cycle_count=6.
3. TimeoutCycles=20, no done.
   -> FAIL after exactly 20 RUN cycles; timeout=1, cycle_count=20, err_mask=0.
4. StopOnErr=0. spy_err=2'b01 at RUN cycle 3, spy_done=2'b11 at cycle 8.
   -> stays in RUN until done, enters DRAIN, ends FAIL with err_mask=2'b01, timeout=0.
5. Edge cases:
   - spy_err and all-done in the same cycle with StopOnErr=1 -> FAIL, not DRAIN.
   - spy_err=2'b10 on the last DRAIN cycle -> FAIL with err_mask=2'b10.
6. rst asserted in DRAIN.
   -> next cycle all outputs 0, state IDLE, no message. A fresh start then runs normally to PASS; start pulses in PASS have no effect.
